// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one instruction at a time through an external
// combinational 8-bit ALU. It reads two operands from a 4x8 register
// file, captures the ALU result and flags, writes back, and keeps a
// register of the flags from the last retired instruction.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic       ld_en,
  input  logic [1:0] ld_sel,
  input  logic [7:0] ld_data,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_rst,
  input  logic [7:0] alu_res,
  input  logic       alu_c_out,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic [2:0] flags,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [7:0] r_regs [4];
  logic [7:0] r_instr;
  logic [7:0] r_result;
  logic [2:0] r_shadow;

  logic       w_accept;
  logic [2:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic       w_cmp;

  // Fields of the latched instruction.
  assign w_op  = r_instr[7:5];
  assign w_rd  = r_instr[4:3];
  assign w_rs  = r_instr[2:1];
  assign w_cmp = r_instr[0];

  assign w_accept = instr_valid && (r_state == IDLE);
  assign dbg_data = r_regs[dbg_sel];
  assign alu_rst  = ~rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, handshake ready and retire pulse.
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_next = READ;
        end
      end
      READ: w_next = EXEC;
      EXEC: w_next = WB;
      WB: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: register file, instruction latch, operands, result and flags.
  // Loads and writeback live in disjoint states, so the file has one writer per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
      r_instr  <= '0;
      r_result <= '0;
      r_shadow <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      flags    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_en) begin
            r_regs[ld_sel] <= ld_data;
          end
          if (w_accept) begin
            r_instr <= instr;
          end
        end
        READ: begin
          alu_a  <= r_regs[w_rd];
          alu_b  <= r_regs[w_rs];
          alu_op <= w_op;
        end
        EXEC: begin
          r_result <= alu_res;
          r_shadow <= {alu_c_out, alu_zero, alu_ovf};
        end
        WB: begin
          if (!w_cmp) begin
            r_regs[w_rd] <= r_result;
          end
          flags <= r_shadow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a small behavioural ALU attached.
// Opcodes used by the ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR,
// 5 NOT, 6 INC, 7 DEC.
module tb_alu_ctrl;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_rst;
  logic [7:0] alu_res;
  logic       alu_c_out;
  logic       alu_zero;
  logic       alu_ovf;
  logic [2:0] flags;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  alu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ld_en       (ld_en),
    .ld_sel      (ld_sel),
    .ld_data     (ld_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_rst     (alu_rst),
    .alu_res     (alu_res),
    .alu_c_out   (alu_c_out),
    .alu_zero    (alu_zero),
    .alu_ovf     (alu_ovf),
    .flags       (flags),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  logic [8:0] m_w;
  always_comb begin
    m_w = '0;
    case (alu_op)
      3'd0: m_w = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: m_w = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: m_w = {1'b0, alu_a & alu_b};
      3'd3: m_w = {1'b0, alu_a | alu_b};
      3'd4: m_w = {1'b0, alu_a ^ alu_b};
      3'd5: m_w = {1'b0, ~alu_a};
      3'd6: m_w = {1'b0, alu_a} + 9'd1;
      default: m_w = {1'b0, alu_a} - 9'd1;
    endcase
  end
  assign alu_res   = m_w[7:0];
  assign alu_c_out = m_w[8];
  assign alu_zero  = (m_w[7:0] == 8'h00);
  assign alu_ovf   = (alu_op == 3'd0) ? ((alu_a[7] == alu_b[7]) && (m_w[7] != alu_a[7])) :
                     (alu_op == 3'd1) ? ((alu_a[7] != alu_b[7]) && (m_w[7] != alu_a[7])) :
                     1'b0;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, {1'b0, dbg_data}, {1'b0, exp});
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_data = data;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Issues one instruction from IDLE and walks it to retirement; optional
  // same-cycle load at accept and a load attempt to R3 while in EXEC.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic cmp,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic with_ld, input logic [1:0] lsel,
                           input logic [7:0] ldat, input logic ld_in_exec);
    instr_valid = 1'b1;
    instr       = {op, rd, rs, cmp};
    if (with_ld) begin
      ld_en   = 1'b1;
      ld_sel  = lsel;
      ld_data = ldat;
    end
    chk({tag, ".ready_idle"}, {8'h0, instr_ready}, 9'h1);
    @(negedge clk);
    instr_valid = 1'b0;
    ld_en       = 1'b0;
    instr       = 8'hE5;
    chk({tag, ".ready_read"}, {8'h0, instr_ready}, 9'h0);
    @(negedge clk);
    chk({tag, ".alu_a"}, {1'b0, alu_a}, {1'b0, ea});
    chk({tag, ".alu_b"}, {1'b0, alu_b}, {1'b0, eb});
    chk({tag, ".alu_op"}, {6'h0, alu_op}, {6'h0, op});
    chk({tag, ".done_exec"}, {8'h0, done}, 9'h0);
    if (ld_in_exec) begin
      ld_en   = 1'b1;
      ld_sel  = 2'd3;
      ld_data = 8'hAA;
    end
    @(negedge clk);
    ld_en = 1'b0;
    chk({tag, ".done_wb"}, {8'h0, done}, 9'h1);
    @(negedge clk);
    chk({tag, ".done_after"}, {8'h0, done}, 9'h0);
    chk({tag, ".ready_after"}, {8'h0, instr_ready}, 9'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 8'h00;
    ld_en       = 1'b0;
    ld_sel      = 2'd0;
    ld_data     = 8'h00;
    dbg_sel     = 2'd0;
    repeat (2) @(negedge clk);
    chk("alu_rst_asserted", {8'h0, alu_rst}, 9'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst.alu_rst", {8'h0, alu_rst}, 9'h0);
    chk("rst.flags", {6'h0, flags}, 9'h0);
    chk("rst.ready", {8'h0, instr_ready}, 9'h1);
    chk("rst.done", {8'h0, done}, 9'h0);
    chk("rst.alu_a", {1'b0, alu_a}, 9'h0);
    chk("rst.alu_op", {6'h0, alu_op}, 9'h0);
    chk_reg("rst.R0", 2'd0, 8'h00);
    chk_reg("rst.R1", 2'd1, 8'h00);
    chk_reg("rst.R2", 2'd2, 8'h00);
    chk_reg("rst.R3", 2'd3, 8'h00);

    // ADD 0x7F + 0x01 -> 0x80, signed overflow.
    load(2'd0, 8'h7F);
    load(2'd1, 8'h01);
    chk_reg("ld.R0", 2'd0, 8'h7F);
    run_instr("add", 3'd0, 2'd0, 2'd1, 1'b0, 8'h7F, 8'h01, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("add.flags", {6'h0, flags}, 9'b0_0000_0001);
    chk_reg("add.R0", 2'd0, 8'h80);

    // SUB compare-only: 5-5 sets z, no writeback.
    load(2'd2, 8'h05);
    load(2'd3, 8'h05);
    run_instr("cmp", 3'd1, 2'd2, 2'd3, 1'b1, 8'h05, 8'h05, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("cmp.flags", {6'h0, flags}, 9'b0_0000_0010);
    chk_reg("cmp.R2", 2'd2, 8'h05);

    // SUB 0 - 1 -> 0xFF with borrow.
    load(2'd2, 8'h00);
    load(2'd3, 8'h01);
    run_instr("sub", 3'd1, 2'd2, 2'd3, 1'b0, 8'h00, 8'h01, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("sub.flags", {6'h0, flags}, 9'b0_0000_0100);
    chk_reg("sub.R2", 2'd2, 8'hFF);

    // NOT with same-cycle load of R0, and an ignored load to R3 in EXEC.
    run_instr("not", 3'd5, 2'd0, 2'd0, 1'b0, 8'h0F, 8'h0F, 1'b1, 2'd0, 8'h0F, 1'b1);
    chk("not.flags", {6'h0, flags}, 9'h0);
    chk_reg("not.R0", 2'd0, 8'hF0);
    chk_reg("not.R3_unchanged", 2'd3, 8'h01);

    // INC 0xFF with instr_valid held high; the second instruction (DEC)
    // presented while busy is accepted only after the first retires.
    load(2'd1, 8'hFF);
    instr_valid = 1'b1;
    instr       = {3'd6, 2'd1, 2'd1, 1'b0};
    @(negedge clk);
    instr = {3'd7, 2'd1, 2'd1, 1'b0};
    chk("b2b.ready_read", {8'h0, instr_ready}, 9'h0);
    @(negedge clk);
    chk("b2b.inc_a", {1'b0, alu_a}, 9'h0FF);
    chk("b2b.inc_op", {6'h0, alu_op}, 9'd6);
    chk("b2b.ready_exec", {8'h0, instr_ready}, 9'h0);
    @(negedge clk);
    chk("b2b.done1", {8'h0, done}, 9'h1);
    chk("b2b.ready_wb", {8'h0, instr_ready}, 9'h0);
    @(negedge clk);
    chk("b2b.ready_idle", {8'h0, instr_ready}, 9'h1);
    chk("b2b.inc_flags", {6'h0, flags}, 9'b0_0000_0110);
    chk_reg("b2b.inc_R1", 2'd1, 8'h00);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b.ready_read2", {8'h0, instr_ready}, 9'h0);
    @(negedge clk);
    chk("b2b.dec_a", {1'b0, alu_a}, 9'h000);
    chk("b2b.dec_op", {6'h0, alu_op}, 9'd7);
    @(negedge clk);
    chk("b2b.done2", {8'h0, done}, 9'h1);
    @(negedge clk);
    chk("b2b.dec_flags", {6'h0, flags}, 9'b0_0000_0100);
    chk_reg("b2b.dec_R1", 2'd1, 8'hFF);

    // Reset asserted during EXEC of ADD aborts with no writeback or done.
    instr_valid = 1'b1;
    instr       = {3'd0, 2'd0, 2'd1, 1'b0};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort.alu_a", {1'b0, alu_a}, 9'h0F0);
    rst_n = 1'b0;
    #1;
    chk("abort.done", {8'h0, done}, 9'h0);
    chk("abort.ready", {8'h0, instr_ready}, 9'h1);
    chk("abort.flags", {6'h0, flags}, 9'h0);
    chk_reg("abort.R0", 2'd0, 8'h00);
    chk_reg("abort.R1", 2'd1, 8'h00);
    chk_reg("abort.R2", 2'd2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort.no_done", {8'h0, done}, 9'h0);
    end
    chk_reg("abort.R0_after", 2'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
